// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle, LSB slice first, registered carry.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' port).

module serial_adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};
endmodule

module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             inv_q, inv_d;
  logic             sub_w;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i (a_q[cnt_q*DIGIT +: DIGIT]),
    .b_i (b_q[cnt_q*DIGIT +: DIGIT]),
    .c_i (carry_q),
    .s_o (dsum),
    .c_o (dcarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // subtract as a + ~b + !c_in; borrow-out is the inverted carry-out
          a_d     = a;
          b_d     = sub_w ? ~b : b;
          carry_d = c_in ^ sub_w;
          inv_d   = sub_w;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[cnt_q*DIGIT +: DIGIT] = dsum;
        carry_d = dcarry;
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = dcarry ^ inv_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 4-bit/1-bit-digit instance plus a 16-bit/4-bit-digit instance.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, c_in, busy, done, c_out;
  logic [3:0]  a, b, sum;
  logic        start16, ci16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub, sub16;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(4), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(ci16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16)
  );

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vci,
                      input logic vsub, input logic [4:0] exp, input string name);
    logic exp_done;
    a = va; b = vb; c_in = vci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vsub;
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; c_in = ~vci;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ~vsub;
`endif
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      exp_done = (k == 4);
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL %s done k=%0d: got %b want %b", name, k, done, exp_done);
      end
      checks++;
      if (busy !== !exp_done) begin
        errors++; $display("FAIL %s busy k=%0d: got %b want %b", name, k, busy, !exp_done);
      end
    end
    checks++;
    if ({c_out, sum} !== exp) begin
      errors++; $display("FAIL %s a=%h b=%h ci=%b sub=%b: got c_out=%b sum=%h want c_out=%b sum=%h",
                         name, va, vb, vci, vsub, c_out, sum, exp[4], exp[3:0]);
    end
  endtask

  task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic vci,
                       input logic [16:0] exp, input string name);
    logic exp_done;
    a16 = va; b16 = vb; ci16 = vci; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'h5A5A; b16 = 16'hA5A5; ci16 = ~vci;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      exp_done = (k == 4);
      checks++;
      if (done16 !== exp_done) begin
        errors++; $display("FAIL %s done k=%0d: got %b want %b", name, k, done16, exp_done);
      end
    end
    checks++;
    if ({cout16, sum16} !== exp) begin
      errors++; $display("FAIL %s: got c_out=%b sum=%h want c_out=%b sum=%h",
                         name, cout16, sum16, exp[16], exp[15:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start16 = 1'b0;
    a = 4'h0; b = 4'h0; c_in = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub16 = 1'b0;
`endif
    #1;
    checks++;
    if ({busy, done, c_out, sum} !== 7'b0) begin
      errors++; $display("FAIL reset4: got busy=%b done=%b c_out=%b sum=%h want all 0", busy, done, c_out, sum);
    end
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'b0) begin
      errors++; $display("FAIL reset16: got busy=%b done=%b c_out=%b sum=%h want all 0", busy16, done16, cout16, sum16);
    end
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_hold: got busy=%b done=%b want 0 0", busy, done);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_ripple;
    run4(4'hF, 4'h0, 1'b1, 1'b0, 5'h10, "ripple");
    run4(4'h3, 4'h4, 1'b0, 1'b0, 5'h07, "simple");
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          run4(4'(i), 4'(j), 1'(c), 1'b0, 5'(i + j + c), "exh");
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    a = 4'd3; b = 4'd5; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      exp_done = (k == 4) || (k == 9);
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL held_start done k=%0d: got %b want %b", k, done, exp_done);
      end
      checks++;
      if (busy !== !exp_done) begin
        errors++; $display("FAIL held_start busy k=%0d: got %b want %b", k, busy, !exp_done);
      end
      if (exp_done) begin
        checks++;
        if ({c_out, sum} !== 5'd8) begin
          errors++; $display("FAIL held_start sum k=%0d: got c_out=%b sum=%h want 0 8", k, c_out, sum);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    a = 4'd7; b = 4'd6; c_in = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, c_out, sum} !== 7'b0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b c_out=%b sum=%h want all 0", busy, done, c_out, sum);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL reset_mid idle k=%0d: got busy=%b done=%b want 0 0", k, busy, done);
      end
    end
    run4(4'd7, 4'd6, 1'b0, 1'b0, 5'd13, "after_reset");
  endtask

  task automatic test_wide;
    run16(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "wide_carry");
    run16(16'h1234, 16'h4321, 1'b1, 17'h05556, "wide_plain");
    run16(16'h8000, 16'h8000, 1'b0, 17'h10000, "wide_msb");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    run4(4'd2, 4'd5, 1'b0, 1'b1, {1'b1, 4'hD}, "sub_borrow");
    run4(4'd9, 4'd3, 1'b1, 1'b1, {1'b0, 4'h5}, "sub_cin");
    run4(4'd9, 4'd3, 1'b1, 1'b0, 5'd13, "add_after_sub");
  endtask
`endif

  initial begin
    test_reset;
    @(negedge clk);
    test_ripple;
    test_exhaustive;
    test_ripple;
    test_back_to_back;
    test_reset_mid;
    test_wide;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 1, meaning bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL provide port clk  input  1  meaning the single clock, rising-edge active.
REQ-004 SHALL provide port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL provide port start  input  1  meaning request to begin an addition.
REQ-006 SHALL provide port a  input  WIDTH  meaning first operand.
REQ-007 SHALL provide port b  input  WIDTH  meaning second operand.
REQ-008 SHALL provide port c_in  input  1  meaning carry-in to the least-significant digit.
REQ-009 SHALL provide port busy  output  1  meaning an addition is in progress.
REQ-010 SHALL provide port done  output  1  meaning a one-cycle result-valid pulse.
REQ-011 SHALL provide port sum  output  WIDTH  meaning the registered result.
REQ-012 SHALL provide port c_out  output  1  meaning the registered carry-out of the MSB.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-014 SHALL sample start only in IDLE or DONE, and on a rising edge with start=1 capture a, b and c_in, clear the digit counter and enter RUN.
REQ-015 SHALL ignore start while in RUN, and the captured operands SHALL be unaffected by changes on a, b or c_in.
REQ-016 SHALL add one DIGIT-bit slice per RUN cycle, LSB slice first, with the carry registered between slices.
REQ-017 SHALL enter DONE on the edge that processes slice N-1, i.e. done is high during the cycle beginning exactly N edges after the start-capture edge.
REQ-018 SHALL update sum and c_out only on the edge entering DONE, and SHALL hold them until the next entry to DONE.
REQ-019 SHALL drive done=1 for exactly one cycle per accepted start, returning to IDLE on the next edge unless start=1 there (REQ-014).
REQ-020 SHALL drive busy=1 in RUN only.
REQ-021 SHALL produce sum = (a + b + c_in) mod 2^WIDTH, and c_out = bit WIDTH of that full sum.
REQ-022 SHALL, for DIGIT = WIDTH, complete in one RUN cycle (N=1).

Reset
REQ-023 SHALL, while rst=1, force state IDLE, counter 0, internal carry 0, busy=0, done=0, sum=0, c_out=0, independent of clk.
REQ-024 SHALL abandon any addition in progress on rst assertion without producing done, and SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_SUB_EN defined, add port sub  input  1, captured with the operands, selecting subtraction when 1.
REQ-026 SHALL, with SERIAL_ADDER_SUB_EN and captured sub=1, produce sum = (a - b - c_in) mod 2^WIDTH and c_out = borrow-out (1 when a < b + c_in), with identical latency.
REQ-027 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and perform addition only.

Verification (WIDTH=4, DIGIT=1 unless noted)
REQ-028 SHALL cover exhaustive a, b in 0..15, c_in in 0..1 -> each sum/c_out equals the 5-bit a+b+c_in, done exactly 4 cycles after the start edge.
REQ-029 SHALL cover a=4'hF, b=4'h0, c_in=1 -> sum=4'h0, c_out=1 (full carry ripple across all slices).
REQ-030 SHALL cover start held high for 10 cycles with a=3, b=5 -> start ignored in RUN, done pulses on cycles 4 and 9 after the first start edge, sum=8 each time, busy low in each DONE cycle.
REQ-031 SHALL cover rst asserted asynchronously mid-RUN (after 2 slices) -> busy, done, sum, c_out go 0 immediately, no done pulse, next start completes correctly.
REQ-032 SHALL cover WIDTH=16, DIGIT=4, a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1, done 4 cycles after the start edge.
REQ-033 SHALL cover, with SERIAL_ADDER_SUB_EN, a=2, b=5, c_in=0, sub=1 -> sum=4'hD, c_out=1; and a=9, b=3, c_in=1, sub=1 -> sum=4'h5, c_out=0.
